// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam int LAT_CNT_W = 4;

  // Illegal size is folded in here so callers get one alignment/legality flag.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lsbs);
    logic bad;
    case (size_e'(size))
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lsbs[0];
      SZ_WORD: bad = (addr_lsbs != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: store byte enables / replicated write data,
// and load lane extraction with sign or zero extension.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [1:0]            lsb_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [31:0]           word_i,
  output logic [3:0]            be_o,
  output logic [31:0]           wdata_o,
  output logic [DATA_WIDTH-1:0] load_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0;
    load_o  = '0;
    byte_v  = word_i[8*lsb_i +: 8];
    half_v  = lsb_i[1] ? word_i[31:16] : word_i[15:0];
    // Write data is replicated across lanes; the byte enables pick the live ones.
    case (size_e'(size_i))
      SZ_BYTE: begin
        be_o    = 4'b0001 << lsb_i;
        wdata_o = {4{wdata_i[7:0]}};
        load_o  = unsigned_i ? DATA_WIDTH'(byte_v) : DATA_WIDTH'($signed(byte_v));
      end
      SZ_HALF: begin
        be_o    = 4'b0011 << {lsb_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        load_o  = unsigned_i ? DATA_WIDTH'(half_v) : DATA_WIDTH'($signed(half_v));
      end
      SZ_WORD: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i[31:0];
        load_o  = DATA_WIDTH'(word_i);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with fixed access latency.
// Memory contents are undefined until written.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 2,
  parameter     INIT_FILE  = "dmem.hex"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [DATA_WIDTH-1:0] ADDR_LIMIT = DATA_WIDTH'(4 * MEM_WORDS);

  state_e                state_q, state_d;
  logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [1:0]            size_q, size_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;

  logic                  acc_we, acc_uns, acc_err, go_resp, mem_we;
  logic [1:0]            acc_size;
  logic [DATA_WIDTH-1:0] acc_addr, acc_wdata, load_data;
  logic [AW-1:0]         acc_idx;
  logic [31:0]           mem [MEM_WORDS];
  logic [31:0]           mem_rd, wdata_sh;
  logic [3:0]            be;

  logic init_file_unused;
  assign init_file_unused = ^INIT_FILE;

  // With LATENCY==1 the access commits on the accept edge, so use live inputs in IDLE.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = req_we_i;
      acc_size  = req_size_i;
      acc_uns   = req_unsigned_i;
      acc_addr  = req_addr_i;
      acc_wdata = req_wdata_i;
    end else begin
      acc_we    = we_q;
      acc_size  = size_q;
      acc_uns   = uns_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
    acc_err = is_misaligned(acc_size, acc_addr[1:0]) || (acc_addr >= ADDR_LIMIT);
    acc_idx = acc_addr[AW+1:2];
  end

  assign mem_rd = mem[acc_idx];

  dmem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane_align (
    .size_i     (acc_size),
    .unsigned_i (acc_uns),
    .lsb_i      (acc_addr[1:0]),
    .wdata_i    (acc_wdata),
    .word_i     (mem_rd),
    .be_o       (be),
    .wdata_o    (wdata_sh),
    .load_o     (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The counter holds the edges still to go; WAIT is left on the edge it reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    go_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          cnt_d   = LAT_CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            go_resp = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - LAT_CNT_W'(1);
        if (cnt_q == LAT_CNT_W'(1)) begin
          go_resp = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (go_resp) begin
      rdata_d = (acc_err || acc_we) ? '0 : load_data;
      err_d   = acc_err;
    end
  end

  assign mem_we = go_resp && acc_we && !acc_err && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[acc_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  always_comb begin
    req_ready_o = (state_q == IDLE);
    rsp_valid_o = (state_q == RESP);
    rsp_rdata_o = rdata_q;
    rsp_err_o   = err_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized bench for dmem_responder against a byte-array model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] ref_mem [4096];

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: memory as a flat byte array, accesses as little-endian byte runs.
  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err);
    int n;
    n     = 1 << size;
    err   = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
            (size == 2'd2 && addr[1:0] != 2'b00) || (addr >= 32'd4096);
    rdata = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) rdata = rdata | (32'(ref_mem[int'(addr) + i]) << (8*i));
        if (n < 4 && !uns && rdata[8*n-1]) rdata = rdata | (32'hFFFF_FFFF << (8*n));
      end
    end
  endfunction

  task automatic op(input string tag, input logic we, input logic [1:0] size, input logic uns,
                    input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                    output logic [31:0] rdata, output logic err);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          waited;
    model(we, size, uns, addr, wdata, exp_rdata, exp_err);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
    chk({tag, "_req_ready_idle"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom(); req_wdata = $urandom(); req_we = ~we;
    chk({tag, "_lat1_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_lat2_valid"}, 32'(rsp_valid), 32'd1);
    waited = 0;
    while (!rsp_valid && waited < 16) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!rsp_valid) begin
      chk({tag, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
      rdata = 'x; err = 1'bx;
      return;
    end
    chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    rdata = rsp_rdata; err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
      chk({tag, "_hold_err"}, 32'(rsp_err), 32'(exp_err));
      chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_post_hs_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_post_hs_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;

    op("st_w10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, r, e);
    chk("st_w10_err_lit", 32'(e), 32'd0);
    op("ld_w10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, r, e);
    chk("ld_w10_lit", r, 32'hDEADBEEF);
    op("ld_bs13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, r, e);
    chk("ld_bs13_lit", r, 32'hFFFFFFDE);
    op("ld_bu13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, r, e);
    chk("ld_bu13_lit", r, 32'h000000DE);
    op("ld_hu12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, r, e);
    chk("ld_hu12_lit", r, 32'h0000DEAD);
    op("ld_hs10", 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 0, r, e);
    chk("ld_hs10_lit", r, 32'hFFFFBEEF);
    op("st_b11", 1'b1, 2'd0, 1'b0, 32'h11, 32'hAAAAAA55, 0, r, e);
    op("ld_w10b", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, r, e);
    chk("ld_w10b_lit", r, 32'hDEAD55EF);

    op("st_w11_mis", 1'b1, 2'd2, 1'b0, 32'h11, 32'h01020304, 0, r, e);
    chk("st_w11_err_lit", 32'(e), 32'd1);
    chk("st_w11_rdata_lit", r, 32'h0);
    op("st_h13_mis", 1'b1, 2'd1, 1'b0, 32'h13, 32'h0000BBBB, 0, r, e);
    chk("st_h13_err_lit", 32'(e), 32'd1);
    op("st_ill", 1'b1, 2'd3, 1'b0, 32'h10, 32'h11111111, 0, r, e);
    chk("st_ill_err_lit", 32'(e), 32'd1);
    op("ld_w10c", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, r, e);
    chk("ld_w10c_lit", r, 32'hDEAD55EF);
    op("st_oor", 1'b1, 2'd2, 1'b0, 32'h1000, 32'hFFFFFFFF, 0, r, e);
    chk("st_oor_err_lit", 32'(e), 32'd1);
    op("ld_hold", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 3, r, e);

    // Store aborted by reset in the wait phase must leave memory untouched.
    op("st_w20", 1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, 0, r, e);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_wait_ready", 32'(req_ready), 32'd1);
    chk("abort_wait_valid", 32'(rsp_valid), 32'd0);
    op("ld_w20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, r, e);
    chk("ld_w20_lit", r, 32'hCAFEF00D);

    // Reset while a response is pending drops it.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h20;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_resp_pre_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_resp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_resp_ready", 32'(req_ready), 32'd1);
    chk("abort_resp_rdata", rsp_rdata, 32'h0);

    for (int w = 0; w < 16; w++) begin
      op("rnd_init", 1'b1, 2'd2, 1'b0, 32'h100 + 32'(4*w), $urandom(), 0, r, e);
    end
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'h1000 + 32'($urandom_range(0, 255));
        1:       a = 32'hFFFF_FFFC;
        default: a = 32'h100 + 32'($urandom_range(0, 63));
      endcase
      op("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
         a, $urandom(), $urandom_range(0, 2), r, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
